adc_capture_window: RTL and testbench
=====================================

ADC_CAPTURE_WINDOW -- requirements
Module: adc_capture_window

Interface
REQ-001 Parameter NBITS, default 128: AXI4-Stream data width (8 x 16-bit samples per beat).
REQ-002 Parameter LEN_BITS, default 12: width of capture length field.
REQ-003 Parameter PRETRIG_BITS, default 4: width of pretrigger depth field (delay line depth 2**PRETRIG_BITS).
REQ-004 aclk  input  1  the only clock, ADC stream clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 s_axis_tdata  input  NBITS  ADC beat from the RFDC stream.
REQ-007 s_axis_tvalid  input  1  ADC beat valid.
REQ-008 s_axis_tready  output  1  always 1; the ADC stream is never stalled.
REQ-009 m_axis_tdata  output  NBITS  captured beat toward buffer stream.
REQ-010 m_axis_tvalid  output  1  captured beat valid.
REQ-011 m_axis_tready  input  1  buffer accepts beat.
REQ-012 capture_i  input  1  single-cycle capture request, already in aclk domain.
REQ-013 pretrig_i  input  PRETRIG_BITS  pretrigger depth P in beats, 0..15.
REQ-014 length_i  input  LEN_BITS  window length minus one; L = length_i+1 beats (1..4096).
REQ-015 busy_o  output  1  high while in CAPTURE.
REQ-016 done_o  output  1  one-cycle pulse when the window completes.
REQ-017 overflow_o  output  1  sticky: a window beat was offered with m_axis_tready low.

Function
REQ-018 Delay line SHALL hold the last 2**PRETRIG_BITS valid input beats, advancing only on s_axis_tvalid=1.
REQ-019 States SHALL be IDLE and CAPTURE.
REQ-020 IDLE -> CAPTURE when capture_i=1; P and L SHALL be latched that cycle; later changes to pretrig_i/length_i ignored until next IDLE.
REQ-021 With x[n] the valid beat in the capture_i cycle (or the next valid beat if s_axis_tvalid=0 then), emitted beats SHALL be x[n-P] .. x[n-P+L-1] in order.
REQ-022 Each emitted beat SHALL appear on m_axis with m_axis_tvalid=1 exactly one cycle after its triggering input beat x[k+P] is accepted (latency 1); m_axis_tvalid=0 in cycles with no accepted input.
REQ-023 Beats not accepted (m_axis_tready=0 while m_axis_tvalid=1) SHALL be dropped, not held; beat counter still advances; overflow_o set.
REQ-024 CAPTURE -> IDLE on the cycle the L-th beat is emitted; done_o=1 that same cycle; busy_o low from the following cycle.
REQ-025 capture_i while in CAPTURE, including the done cycle, SHALL be ignored.
REQ-026 overflow_o SHALL clear on the IDLE -> CAPTURE transition and otherwise hold until rst.
REQ-027 Delay-line entries never written since reset SHALL read as all-zero.
REQ-028 Beat counter SHALL be LEN_BITS wide; L=4096 (length_i all ones) SHALL complete without wrap error.

Reset
REQ-029 On rst=1: state IDLE, busy_o=0, done_o=0, overflow_o=0, m_axis_tvalid=0, m_axis_tdata=0, delay line zeroed, beat counter 0.
REQ-030 rst mid-capture SHALL abort immediately with no done_o pulse; next cycle after rst deasserts accepts capture_i.

Structure
REQ-031 Package adc_capture_pkg SHALL hold the state enum (IDLE, CAPTURE) and default NBITS/LEN_BITS/PRETRIG_BITS constants.
REQ-032 Delay line SHALL be a sub-module adc_beat_delay (shift register, tap select by P, enable = s_axis_tvalid).

Verification
REQ-033 Ramp input (beat k = k), continuous valid, capture at beat 100, P=0, L=4 -> outputs 100,101,102,103, done_o with beat 103, busy_o low after.
REQ-034 Same ramp, P=8, L=16, capture at beat 200 -> outputs 192..207, latency 1 cycle per beat.
REQ-035 Valid toggles 1/0, P=3, L=5, capture at beat 50 -> outputs 47..51, m_axis_tvalid gaps mirror input gaps.
REQ-036 m_axis_tready low for beat 2 of L=4 window -> that beat dropped, done_o after beat 4, overflow_o=1 until next capture.
REQ-037 Capture 2 cycles after reset, P=5 -> first 3 outputs zero; capture_i repeated during CAPTURE -> ignored, single done_o.
REQ-038 rst asserted mid-window of L=4096 -> m_axis_tvalid=0, busy_o=0 next cycle, no done_o; new capture then completes 4096 beats.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types and default sizing for the ADC capture window.
// An ADC beat is 8 x 16-bit samples.
package adc_capture_pkg;

    localparam int DEF_NBITS        = 128;
    localparam int DEF_LEN_BITS     = 12;
    localparam int DEF_PRETRIG_BITS = 4;

    typedef enum logic {
        IDLE,
        CAPTURE
    } cap_state_t;

endpackage

// File: rtl/adc_capture_window_delay.sv
// Pretrigger history: a shift register of the most recent valid ADC beats.
// The tap can also select the beat arriving right now, with no delay.
module adc_beat_delay
    import adc_capture_pkg::*;
#(
    parameter int NBITS        = DEF_NBITS,
    parameter int PRETRIG_BITS = DEF_PRETRIG_BITS
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [NBITS-1:0]        i_data,
    input  logic [PRETRIG_BITS-1:0] i_sel,
    output logic [NBITS-1:0]        o_tap
);

    localparam int DEPTH = 2 ** PRETRIG_BITS;

    logic [NBITS-1:0]        r_line [DEPTH];
    logic [PRETRIG_BITS-1:0] w_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_line[i] <= '0;
            end
        end else if (i_en) begin
            r_line[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_line[i] <= r_line[i-1];
            end
        end
    end

    // A select of P means "P valid beats before the current one".
    // Entry 0 therefore holds a delay of 1.
    assign w_idx = i_sel - 1'b1;
    assign o_tap = (i_sel == '0) ? i_data : r_line[w_idx];

endmodule

// File: rtl/adc_capture_window.sv
// Captures a window of L ADC beats, starting P beats before the trigger beat.
// The window streams out with one cycle of latency and is never back-pressured.
module adc_capture_window
    import adc_capture_pkg::*;
#(
    parameter int NBITS        = DEF_NBITS,
    parameter int LEN_BITS     = DEF_LEN_BITS,
    parameter int PRETRIG_BITS = DEF_PRETRIG_BITS
) (
    input  logic                    aclk,
    input  logic                    rst,
    input  logic [NBITS-1:0]        s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [NBITS-1:0]        m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    input  logic                    capture_i,
    input  logic [PRETRIG_BITS-1:0] pretrig_i,
    input  logic [LEN_BITS-1:0]     length_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    overflow_o
);

    cap_state_t              r_state;
    logic [PRETRIG_BITS-1:0] r_pretrig;
    logic [LEN_BITS-1:0]     r_len;
    logic [LEN_BITS-1:0]     r_count;
    logic                    r_done;
    logic                    r_busy;
    logic                    r_overflow;
    logic                    r_tvalid;
    logic [NBITS-1:0]        r_tdata;

    logic                    w_idle;
    logic                    w_start;
    logic                    w_issue;
    logic                    w_last;
    logic [PRETRIG_BITS-1:0] w_sel;
    logic [LEN_BITS-1:0]     w_cnt;
    logic [LEN_BITS-1:0]     w_len;
    logic [NBITS-1:0]        w_tap;

    // The trigger beat may arrive in the same cycle as capture_i.
    // So that cycle uses the live P/L inputs instead of the latched copies.
    assign w_idle  = (r_state == IDLE);
    assign w_start = w_idle && capture_i;
    assign w_sel   = w_idle ? pretrig_i : r_pretrig;
    assign w_cnt   = w_start ? '0 : r_count;
    assign w_len   = w_start ? length_i : r_len;
    assign w_last  = (w_cnt == w_len);
    assign w_issue = s_axis_tvalid && (w_start || ((r_state == CAPTURE) && !r_done));

    adc_beat_delay #(
        .NBITS        (NBITS),
        .PRETRIG_BITS (PRETRIG_BITS)
    ) u_delay (
        .i_clk  (aclk),
        .i_rst  (rst),
        .i_en   (s_axis_tvalid),
        .i_data (s_axis_tdata),
        .i_sel  (w_sel),
        .o_tap  (w_tap)
    );

    // The done cycle stays in CAPTURE so busy_o covers it and capture_i is ignored.
    // No new beat is issued during the done cycle.
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pretrig  <= '0;
            r_len      <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
        end else begin
            r_tvalid <= w_issue;
            r_done   <= w_issue && w_last;
            if (w_issue) begin
                r_tdata <= w_tap;
                r_count <= w_cnt + 1'b1;
            end else if (w_start) begin
                r_count <= '0;
            end

            if (w_start) begin
                r_overflow <= 1'b0;
            end else if (r_tvalid && !m_axis_tready) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (capture_i) begin
                        r_state   <= CAPTURE;
                        r_busy    <= 1'b1;
                        r_pretrig <= pretrig_i;
                        r_len     <= length_i;
                    end
                end
                CAPTURE: begin
                    if (r_done) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis_tready = 1'b1;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_adc_capture_window.sv
// Bench for adc_capture_window: ramp and random traffic checked against a
// queue-based model of the capture window.
module tb_adc_capture_window;

    localparam int NB = 128;
    localparam int LB = 12;
    localparam int PB = 4;

    logic          aclk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [NB-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          capture_i = 1'b0;
    logic [PB-1:0] pretrig_i = '0;
    logic [LB-1:0] length_i = '0;
    logic          busy_o;
    logic          done_o;
    logic          overflow_o;

    int errors = 0;
    int checks = 0;
    int cycleNo = 0;

    // Model state: full history of accepted beats since reset, plus window bookkeeping.
    logic [NB-1:0] hist[$];
    bit            winOpen = 0;
    int            wP = 0;
    int            wLeft = 0;
    bit            expValid = 0, expDone = 0, expBusy = 0, expOvf = 0;
    logic [NB-1:0] expData = '0;

    adc_capture_window #(
        .NBITS        (NB),
        .LEN_BITS     (LB),
        .PRETRIG_BITS (PB)
    ) dut (
        .aclk          (aclk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .capture_i     (capture_i),
        .pretrig_i     (pretrig_i),
        .length_i      (length_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .overflow_o    (overflow_o)
    );

    always #5 aclk = ~aclk;

    // Predict the outputs that follow this cycle's inputs, then advance one clock.
    task automatic tick();
        bit            nValid, nDone, nBusy, nOvf;
        logic [NB-1:0] nData;
        int            idx;
        nValid = 0;
        nDone  = 0;
        nData  = expData;
        if (rst) begin
            hist.delete();
            winOpen = 0;
            wLeft   = 0;
            nBusy   = 0;
            nOvf    = 0;
            nData   = '0;
        end else begin
            nOvf = expOvf || (expValid && !m_axis_tready);
            if (expDone) begin
                winOpen = 0;
            end else if (!expBusy && capture_i) begin
                winOpen = 1;
                wP      = int'(pretrig_i);
                wLeft   = int'(length_i) + 1;
                nOvf    = 0;
            end
            if (s_axis_tvalid) begin
                hist.push_back(s_axis_tdata);
                if (winOpen && wLeft > 0) begin
                    idx    = hist.size() - 1;
                    nValid = 1;
                    nData  = (idx >= wP) ? hist[idx-wP] : '0;
                    wLeft--;
                    nDone  = (wLeft == 0);
                end
            end
            nBusy = winOpen;
        end
        @(posedge aclk);
        #1;
        expValid = nValid;
        expDone  = nDone;
        expBusy  = nBusy;
        expOvf   = nOvf;
        expData  = nData;
        cycleNo++;
    endtask

    task automatic doReset();
        rst           = 1'b1;
        capture_i     = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        for (int c = 0; c < 30; c++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
            capture_i     = (c == 3);
            pretrig_i     = 4'd2;
            length_i      = 12'd40;
            m_axis_tready = !(c >= 10 && c < 13);
            tick();
            checks++;
            if ({m_axis_tvalid, done_o, busy_o, overflow_o, s_axis_tready} !== {expValid, expDone, expBusy, expOvf, 1'b1}) begin
                errors++;
                $display("[TB] FAIL reset_traffic_ctl cycle %0d: got v/d/b/o/r=%b want %b", cycleNo,
                         {m_axis_tvalid, done_o, busy_o, overflow_o, s_axis_tready}, {expValid, expDone, expBusy, expOvf, 1'b1});
            end
            if (expValid) begin
                checks++;
                if (m_axis_tdata !== expData) begin
                    errors++;
                    $display("[TB] FAIL reset_traffic_data cycle %0d: got %h want %h", cycleNo, m_axis_tdata, expData);
                end
            end
        end
        rst       = 1'b1;
        capture_i = 1'b0;
        tick();
        checks++;
        if ({m_axis_tvalid, done_o, busy_o, overflow_o} !== 4'b0000 || m_axis_tdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got v/d/b/o=%b data=%h want 0000 data=0",
                     {m_axis_tvalid, done_o, busy_o, overflow_o}, m_axis_tdata);
        end
        rst = 1'b0;
    endtask

    // Ramp data (beat k carries k), continuous or every-other-cycle valid.
    task automatic test_ramp(input int capBeat, input int p, input int len, input bit gapped, input string name);
        logic [NB-1:0] got[$];
        int            k = 0;
        int            dones = 0;
        int            nCycles;
        bit            v;
        doReset();
        nCycles = (gapped ? 2 : 1) * (capBeat + len + 10);
        for (int c = 0; c < nCycles; c++) begin
            v             = gapped ? (c % 2 == 0) : 1'b1;
            s_axis_tvalid = v;
            s_axis_tdata  = NB'(k);
            capture_i     = v && (k == capBeat);
            pretrig_i     = PB'(p);
            length_i      = LB'(len - 1);
            m_axis_tready = 1'b1;
            if (v) k++;
            tick();
            checks++;
            if ({m_axis_tvalid, done_o, busy_o, overflow_o, s_axis_tready} !== {expValid, expDone, expBusy, expOvf, 1'b1}) begin
                errors++;
                $display("[TB] FAIL %s_ctl cycle %0d: got v/d/b/o/r=%b want %b", name, cycleNo,
                         {m_axis_tvalid, done_o, busy_o, overflow_o, s_axis_tready}, {expValid, expDone, expBusy, expOvf, 1'b1});
            end
            if (expValid) begin
                checks++;
                if (m_axis_tdata !== expData) begin
                    errors++;
                    $display("[TB] FAIL %s_data cycle %0d: got %h want %h", name, cycleNo, m_axis_tdata, expData);
                end
            end
            if (m_axis_tvalid) got.push_back(m_axis_tdata);
            if (done_o) begin
                dones++;
                checks++;
                if (m_axis_tdata !== NB'(capBeat - p + len - 1)) begin
                    errors++;
                    $display("[TB] FAIL %s_done_beat: got %0d want %0d", name, m_axis_tdata, capBeat - p + len - 1);
                end
            end
        end
        checks++;
        if (got.size() != len || dones != 1 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_summary: got beats=%0d dones=%0d busy=%b want %0d 1 0", name, got.size(), dones, busy_o, len);
        end
        for (int i = 0; i < got.size() && i < len; i++) begin
            checks++;
            if (got[i] !== NB'(capBeat - p + i)) begin
                errors++;
                $display("[TB] FAIL %s_beat%0d: got %0d want %0d", name, i, got[i], capBeat - p + i);
            end
        end
    endtask

    task automatic test_overflow();
        int accepted = 0;
        int shown = 0;
        doReset();
        for (int c = 0; c < 50; c++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = NB'(c);
            capture_i     = (c == 20) || (c == 40);
            pretrig_i     = '0;
            length_i      = 12'd3;
            m_axis_tready = (c != 22);
            tick();
            checks++;
            if ({m_axis_tvalid, done_o, busy_o, overflow_o, s_axis_tready} !== {expValid, expDone, expBusy, expOvf, 1'b1}) begin
                errors++;
                $display("[TB] FAIL overflow_ctl cycle %0d: got v/d/b/o/r=%b want %b", cycleNo,
                         {m_axis_tvalid, done_o, busy_o, overflow_o, s_axis_tready}, {expValid, expDone, expBusy, expOvf, 1'b1});
            end
            if (expValid) begin
                checks++;
                if (m_axis_tdata !== expData) begin
                    errors++;
                    $display("[TB] FAIL overflow_data cycle %0d: got %h want %h", cycleNo, m_axis_tdata, expData);
                end
            end
            if (c < 40 && m_axis_tvalid) begin
                shown++;
                if (c + 1 != 22 + 1 && c != 22) accepted++;
            end
            if (c == 39) begin
                checks++;
                if (overflow_o !== 1'b1 || shown != 4 || busy_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL overflow_sticky: got ovf=%b beats=%0d busy=%b want 1 4 0", overflow_o, shown, busy_o);
                end
            end
            if (c == 40) begin
                checks++;
                if (overflow_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL overflow_clear: got %b want 0", overflow_o);
                end
            end
        end
    endtask

    task automatic test_early_capture();
        logic [NB-1:0] sent[$];
        logic [NB-1:0] got[$];
        int            dones = 0;
        doReset();
        for (int c = 0; c < 20; c++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom} | NB'(1);
            sent.push_back(s_axis_tdata);
            capture_i     = (c == 2) || (c == 4) || (c == 5) || (c == 10);
            pretrig_i     = 4'd5;
            length_i      = 12'd7;
            m_axis_tready = 1'b1;
            tick();
            checks++;
            if ({m_axis_tvalid, done_o, busy_o, overflow_o, s_axis_tready} !== {expValid, expDone, expBusy, expOvf, 1'b1}) begin
                errors++;
                $display("[TB] FAIL early_ctl cycle %0d: got v/d/b/o/r=%b want %b", cycleNo,
                         {m_axis_tvalid, done_o, busy_o, overflow_o, s_axis_tready}, {expValid, expDone, expBusy, expOvf, 1'b1});
            end
            if (expValid) begin
                checks++;
                if (m_axis_tdata !== expData) begin
                    errors++;
                    $display("[TB] FAIL early_data cycle %0d: got %h want %h", cycleNo, m_axis_tdata, expData);
                end
            end
            if (m_axis_tvalid) got.push_back(m_axis_tdata);
            if (done_o) dones++;
        end
        checks++;
        if (got.size() != 8 || dones != 1) begin
            errors++;
            $display("[TB] FAIL early_summary: got beats=%0d dones=%0d want 8 1", got.size(), dones);
        end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            checks++;
            if (got[i] !== ((i < 3) ? NB'(0) : sent[i-3])) begin
                errors++;
                $display("[TB] FAIL early_beat%0d: got %h want %h", i, got[i], (i < 3) ? NB'(0) : sent[i-3]);
            end
        end
    endtask

    task automatic test_abort_long();
        int beats = 0;
        int dones = 0;
        int lastBeatAt = -1;
        int doneAt = -2;
        doReset();
        for (int c = 0; c < 5120; c++) begin
            rst           = (c == 1005);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
            capture_i     = (c == 5) || (c == 1006);
            pretrig_i     = 4'd3;
            length_i      = '1;
            m_axis_tready = 1'b1;
            tick();
            checks++;
            if ({m_axis_tvalid, done_o, busy_o, overflow_o, s_axis_tready} !== {expValid, expDone, expBusy, expOvf, 1'b1}) begin
                errors++;
                $display("[TB] FAIL abort_ctl cycle %0d: got v/d/b/o/r=%b want %b", cycleNo,
                         {m_axis_tvalid, done_o, busy_o, overflow_o, s_axis_tready}, {expValid, expDone, expBusy, expOvf, 1'b1});
            end
            if (expValid) begin
                checks++;
                if (m_axis_tdata !== expData) begin
                    errors++;
                    $display("[TB] FAIL abort_data cycle %0d: got %h want %h", cycleNo, m_axis_tdata, expData);
                end
            end
            if (c == 1005) begin
                checks++;
                if ({m_axis_tvalid, busy_o, done_o} !== 3'b000 || dones != 0) begin
                    errors++;
                    $display("[TB] FAIL abort_now: got v/b/d=%b dones=%0d want 000 0", {m_axis_tvalid, busy_o, done_o}, dones);
                end
            end
            if (c > 1005 && m_axis_tvalid) begin
                beats++;
                if (beats == 4096) lastBeatAt = c;
            end
            if (done_o) begin
                dones++;
                doneAt = c;
            end
        end
        rst = 1'b0;
        checks++;
        if (beats != 4096 || dones != 1 || doneAt != lastBeatAt || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_full_window: got beats=%0d dones=%0d done@%0d last@%0d busy=%b want 4096 1 equal 0",
                     beats, dones, doneAt, lastBeatAt, busy_o);
        end
    endtask

    task automatic test_random();
        doReset();
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(0, 399) == 0);
            s_axis_tvalid = ($urandom_range(0, 3) != 0);
            s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
            capture_i     = ($urandom_range(0, 19) == 0);
            pretrig_i     = PB'($urandom_range(0, 15));
            length_i      = LB'($urandom_range(0, 20));
            m_axis_tready = ($urandom_range(0, 6) != 0);
            tick();
            checks++;
            if ({m_axis_tvalid, done_o, busy_o, overflow_o, s_axis_tready} !== {expValid, expDone, expBusy, expOvf, 1'b1}) begin
                errors++;
                $display("[TB] FAIL random_ctl cycle %0d: got v/d/b/o/r=%b want %b", cycleNo,
                         {m_axis_tvalid, done_o, busy_o, overflow_o, s_axis_tready}, {expValid, expDone, expBusy, expOvf, 1'b1});
            end
            if (expValid) begin
                checks++;
                if (m_axis_tdata !== expData) begin
                    errors++;
                    $display("[TB] FAIL random_data cycle %0d: got %h want %h", cycleNo, m_axis_tdata, expData);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp(100, 0, 4, 1'b0, "ramp_p0");
        test_ramp(200, 8, 16, 1'b0, "ramp_p8");
        test_ramp(50, 3, 5, 1'b1, "gapped");
        test_overflow();
        test_early_capture();
        test_abort_long();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
